// File: rtl/xbar_pkg.sv
// Shared sizing constants and helpers for the 8x8 crossbar scheduler.
package xbar_pkg;

   localparam int unsigned NPORT            = 8;
   localparam int unsigned IDXW             = 3;
   localparam int unsigned AW               = 4;
   localparam int unsigned ADDR_INVALID_BIT = AW - 1;

   function automatic logic [NPORT-1:0] onehot(input logic [IDXW-1:0] idx);
      logic [NPORT-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Returns {found, idx}: first set bit of reqvec at or above ptr, wrapping to 0.
   function automatic logic [IDXW:0] rr_pick(input logic [NPORT-1:0] reqvec,
                                             input logic [IDXW-1:0]  ptr);
      logic            found;
      logic [IDXW-1:0] idx;
      logic [IDXW-1:0] cand;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NPORT; k++) begin
         cand = ptr + k[IDXW-1:0];
         if (!found && reqvec[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/xbar_scheduler_rr_arb_slice.sv
// Round-robin arbiter for one output port; owns that output's priority pointer.
module rr_arb_slice
   import xbar_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic [NPORT-1:0] req,
   input  logic             full,
   output logic             win,
   output logic [IDXW-1:0]  win_idx
);

   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW:0]   pick;

   always_comb begin
      pick    = rr_pick(req, ptr_q);
      win     = pick[IDXW] & ~full;
      win_idx = pick[IDXW-1:0];
      ptr_d   = ptr_q;
      if (win) begin
         ptr_d = win_idx + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/xbar_scheduler.sv
// Crossbar scheduler: latches one request per input, arbitrates per output,
// registers grant / mux select / FIFO push.
module xbar_scheduler
   import xbar_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [NPORT-1:0]        req_vld,
   input  logic [NPORT*AW-1:0]     req_addr,
   input  logic [NPORT-1:0]        fifo_full,
   output logic [NPORT-1:0]        pend,
   output logic [NPORT*NPORT-1:0]  grant,
   output logic [NPORT*IDXW-1:0]   grant_idx,
   output logic [NPORT-1:0]        push,
   output logic [NPORT-1:0]        drop
);

   logic [NPORT-1:0]       pend_q, pend_d;
   logic [NPORT-1:0]       drop_q, drop_d;
   logic [NPORT-1:0]       push_q, push_d;
   logic [IDXW-1:0]        dest_q [NPORT];
   logic [IDXW-1:0]        dest_d [NPORT];
   logic [NPORT*NPORT-1:0] grant_q, grant_d;
   logic [NPORT*IDXW-1:0]  gidx_q, gidx_d;

   logic [NPORT-1:0]       cand [NPORT];
   logic [NPORT-1:0]       win;
   logic [IDXW-1:0]        win_idx [NPORT];
   logic [NPORT-1:0]       taken;

   always_comb begin
      for (int j = 0; j < NPORT; j++) begin
         cand[j] = '0;
         for (int i = 0; i < NPORT; i++) begin
            cand[j][i] = pend_q[i] && (dest_q[i] == j[IDXW-1:0]);
         end
      end
   end

   for (genvar j = 0; j < NPORT; j++) begin : g_arb
      rr_arb_slice u_arb (
         .clock   (clock),
         .reset_n (reset_n),
         .req     (cand[j]),
         .full    (fifo_full[j]),
         .win     (win[j]),
         .win_idx (win_idx[j])
      );
   end

   // An input has a single destination, so at most one output can take it.
   always_comb begin
      taken = '0;
      for (int j = 0; j < NPORT; j++) begin
         if (win[j]) begin
            taken = taken | onehot(win_idx[j]);
         end
      end
   end

   always_comb begin
      logic [AW-1:0] addr;
      addr   = '0;
      pend_d = pend_q & ~taken;
      drop_d = '0;
      dest_d = dest_q;
      for (int i = 0; i < NPORT; i++) begin
         addr = req_addr[i*AW +: AW];
         if (req_vld[i]) begin
            if (addr[ADDR_INVALID_BIT]) begin
               drop_d[i] = 1'b1;
            end else if (!pend_q[i] || taken[i]) begin
               pend_d[i] = 1'b1;
               dest_d[i] = addr[IDXW-1:0];
            end else begin
               drop_d[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      grant_d = '0;
      gidx_d  = '0;
      push_d  = win;
      for (int j = 0; j < NPORT; j++) begin
         if (win[j]) begin
            grant_d[j*NPORT +: NPORT] = onehot(win_idx[j]);
            gidx_d[j*IDXW +: IDXW]    = win_idx[j];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pend_q  <= '0;
         drop_q  <= '0;
         push_q  <= '0;
         grant_q <= '0;
         gidx_q  <= '0;
         for (int i = 0; i < NPORT; i++) begin
            dest_q[i] <= '0;
         end
      end else begin
         pend_q  <= pend_d;
         drop_q  <= drop_d;
         push_q  <= push_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         for (int i = 0; i < NPORT; i++) begin
            dest_q[i] <= dest_d[i];
         end
      end
   end

   assign pend      = pend_q;
   assign drop      = drop_q;
   assign push      = push_q;
   assign grant     = grant_q;
   assign grant_idx = gidx_q;

endmodule

// File: tb/tb_xbar_scheduler.sv
// Scenario tests plus randomized run against a per-cycle reference model of the scheduler.
module tb_xbar_scheduler;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [7:0]  req_vld;
   logic [31:0] req_addr;
   logic [7:0]  fifo_full;
   logic [7:0]  pend;
   logic [63:0] grant;
   logic [23:0] grant_idx;
   logic [7:0]  push;
   logic [7:0]  drop;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_pend[8], m_dest[8], m_ptr[8], m_push[8], m_gidx[8], m_drop[8];
   logic [7:0] prev_full;

   xbar_scheduler dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_vld   (req_vld),
      .req_addr  (req_addr),
      .fifo_full (fifo_full),
      .pend      (pend),
      .grant     (grant),
      .grant_idx (grant_idx),
      .push      (push),
      .drop      (drop)
   );

   always #5 clock = ~clock;

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         m_pend[i] = 0; m_dest[i] = 0; m_ptr[i] = 0;
         m_push[i] = 0; m_gidx[i] = 0; m_drop[i] = 0;
      end
      prev_full = '0;
   endtask

   // Advance one clock: evaluate the model on the current inputs, then step the DUT.
   task automatic cycle();
      int n_pend[8], n_dest[8], n_ptr[8], n_push[8], n_gidx[8], n_drop[8], tk[8];
      int c, a;
      n_pend = m_pend; n_dest = m_dest; n_ptr = m_ptr;
      for (int i = 0; i < 8; i++) begin
         n_push[i] = 0; n_gidx[i] = 0; n_drop[i] = 0; tk[i] = 0;
      end
      for (int j = 0; j < 8; j++) begin
         if (!fifo_full[j]) begin
            for (int k = 0; k < 8; k++) begin
               c = (m_ptr[j] + k) % 8;
               if (n_push[j] == 0 && m_pend[c] != 0 && m_dest[c] == j) begin
                  n_push[j] = 1; n_gidx[j] = c; n_ptr[j] = (c + 1) % 8; tk[c] = 1;
               end
            end
         end
      end
      for (int i = 0; i < 8; i++) begin
         if (tk[i] != 0) n_pend[i] = 0;
         if (req_vld[i]) begin
            a = int'(req_addr[i*4 +: 4]);
            if (a >= 8) n_drop[i] = 1;
            else if (m_pend[i] == 0 || tk[i] != 0) begin
               n_pend[i] = 1; n_dest[i] = a;
            end else n_drop[i] = 1;
         end
      end
      @(posedge clock);
      m_pend = n_pend; m_dest = n_dest; m_ptr = n_ptr;
      m_push = n_push; m_gidx = n_gidx; m_drop = n_drop;
      prev_full = fifo_full;
      #1;
   endtask

   task automatic do_reset();
      req_vld = '0; req_addr = '0; fifo_full = '0;
      @(negedge clock);
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      req_vld = '0; req_addr = '0; fifo_full = '0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      total++; if (pend !== 8'h00) begin bad++; $display("FAIL reset_pend got=%h want=00", pend); end
      total++; if (push !== 8'h00) begin bad++; $display("FAIL reset_push got=%h want=00", push); end
      total++; if (grant !== 64'h0) begin bad++; $display("FAIL reset_grant got=%h want=0", grant); end
      total++; if (grant_idx !== 24'h0) begin bad++; $display("FAIL reset_gidx got=%h want=0", grant_idx); end
      total++; if (drop !== 8'h00) begin bad++; $display("FAIL reset_drop got=%h want=00", drop); end
      #1 reset_n = 1'b1;
      model_clear();
   endtask

   task automatic test_single();
      do_reset();
      req_vld[3] = 1'b1; req_addr[12 +: 4] = 4'd5;
      cycle();
      req_vld = '0; req_addr = '0;
      total++; if (pend !== 8'h08) begin bad++; $display("FAIL single_pend got=%h want=08", pend); end
      total++; if (push !== 8'h00) begin bad++; $display("FAIL single_early_push got=%h want=00", push); end
      cycle();
      total++; if (push !== 8'h20) begin bad++; $display("FAIL single_push got=%h want=20", push); end
      total++; if (grant[40 +: 8] !== 8'h08) begin bad++; $display("FAIL single_grant got=%h want=08", grant[40 +: 8]); end
      total++; if (grant_idx[15 +: 3] !== 3'd3) begin bad++; $display("FAIL single_gidx got=%0d want=3", grant_idx[15 +: 3]); end
      total++; if (pend !== 8'h00) begin bad++; $display("FAIL single_pend_clr got=%h want=00", pend); end
      cycle();
      total++; if (push !== 8'h00) begin bad++; $display("FAIL single_push_once got=%h want=00", push); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_g[3];
      logic [7:0] exp_p[3];
      exp_g[0] = 8'h01; exp_g[1] = 8'h04; exp_g[2] = 8'h80;
      exp_p[0] = 8'h84; exp_p[1] = 8'h80; exp_p[2] = 8'h00;
      do_reset();
      req_vld = 8'h85;
      req_addr[0 +: 4] = 4'd4; req_addr[8 +: 4] = 4'd4; req_addr[28 +: 4] = 4'd4;
      cycle();
      req_vld = '0; req_addr = '0;
      total++; if (pend !== 8'h85) begin bad++; $display("FAIL contend_pend got=%h want=85", pend); end
      for (int n = 0; n < 3; n++) begin
         cycle();
         total++; if (push !== 8'h10 || grant[32 +: 8] !== exp_g[n]) begin
            bad++; $display("FAIL contend_grant%0d got push=%h g=%h want push=10 g=%h", n, push, grant[32 +: 8], exp_g[n]);
         end
         total++; if (pend !== exp_p[n]) begin bad++; $display("FAIL contend_pend%0d got=%h want=%h", n, pend, exp_p[n]); end
      end
      // Pointer wrapped back to 0: input 0 must now beat input 7.
      req_vld = 8'h81; req_addr[0 +: 4] = 4'd4; req_addr[28 +: 4] = 4'd4;
      cycle();
      req_vld = '0; req_addr = '0;
      cycle();
      total++; if (grant[32 +: 8] !== 8'h01) begin bad++; $display("FAIL contend_ptr_wrap got=%h want=01", grant[32 +: 8]); end
      cycle();
   endtask

   task automatic test_backpressure();
      do_reset();
      fifo_full = 8'h02;
      req_vld = 8'h42; req_addr[4 +: 4] = 4'd1; req_addr[24 +: 4] = 4'd1;
      cycle();
      req_vld = '0; req_addr = '0;
      for (int n = 0; n < 3; n++) begin
         cycle();
         total++; if (push !== 8'h00 || pend !== 8'h42) begin
            bad++; $display("FAIL bp_hold%0d got push=%h pend=%h want push=00 pend=42", n, push, pend);
         end
      end
      fifo_full = '0;
      cycle();
      total++; if (push !== 8'h02 || grant[8 +: 8] !== 8'h02) begin
         bad++; $display("FAIL bp_first got push=%h g=%h want push=02 g=02", push, grant[8 +: 8]);
      end
      cycle();
      total++; if (grant[8 +: 8] !== 8'h40 || pend !== 8'h00) begin
         bad++; $display("FAIL bp_second got g=%h pend=%h want g=40 pend=00", grant[8 +: 8], pend);
      end
   endtask

   task automatic test_drop();
      do_reset();
      fifo_full = 8'h08;
      req_vld[2] = 1'b1; req_addr[8 +: 4] = 4'd3;
      cycle();
      req_addr[8 +: 4] = 4'd6;
      cycle();
      req_vld = '0; req_addr = '0;
      total++; if (drop !== 8'h04 || pend !== 8'h04) begin
         bad++; $display("FAIL drop_busy got drop=%h pend=%h want drop=04 pend=04", drop, pend);
      end
      fifo_full = '0;
      cycle();
      total++; if (push !== 8'h08 || grant_idx[9 +: 3] !== 3'd2 || drop !== 8'h00) begin
         bad++; $display("FAIL drop_keep_dest got push=%h idx=%0d drop=%h want push=08 idx=2 drop=00",
                         push, grant_idx[9 +: 3], drop);
      end
      req_vld[5] = 1'b1; req_addr[20 +: 4] = 4'b1010;
      cycle();
      req_vld = '0; req_addr = '0;
      total++; if (drop !== 8'h20 || pend !== 8'h00) begin
         bad++; $display("FAIL drop_invalid got drop=%h pend=%h want drop=20 pend=00", drop, pend);
      end
      cycle();
      total++; if (push !== 8'h00 || drop !== 8'h00) begin
         bad++; $display("FAIL drop_after got push=%h drop=%h want 00 00", push, drop);
      end
   endtask

   task automatic test_parallel();
      logic [63:0] eg;
      do_reset();
      req_vld = 8'hFF;
      for (int i = 0; i < 8; i++) req_addr[i*4 +: 4] = 4'(7 - i);
      cycle();
      req_vld = '0; req_addr = '0;
      total++; if (pend !== 8'hFF) begin bad++; $display("FAIL par_pend got=%h want=ff", pend); end
      cycle();
      eg = '0;
      for (int j = 0; j < 8; j++) eg[j*8 + (7 - j)] = 1'b1;
      total++; if (push !== 8'hFF) begin bad++; $display("FAIL par_push got=%h want=ff", push); end
      total++; if (grant !== eg) begin bad++; $display("FAIL par_grant got=%h want=%h", grant, eg); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fifo_full = 8'hFE;
      req_vld = 8'hFF;
      for (int i = 0; i < 8; i++) req_addr[i*4 +: 4] = 4'(i);
      cycle();
      req_vld = '0; req_addr = '0;
      cycle();
      total++; if (push !== 8'h01 || pend !== 8'hFE) begin
         bad++; $display("FAIL mid_pre got push=%h pend=%h want push=01 pend=fe", push, pend);
      end
      #2 reset_n = 1'b0;
      #1;
      total++; if (pend !== 8'h00 || push !== 8'h00 || grant !== 64'h0) begin
         bad++; $display("FAIL mid_async got pend=%h push=%h grant=%h want all 0", pend, push, grant);
      end
      #1 reset_n = 1'b1;
      model_clear();
      fifo_full = '0;
      for (int n = 0; n < 3; n++) begin
         cycle();
         total++; if (push !== 8'h00 || pend !== 8'h00) begin
            bad++; $display("FAIL mid_after%0d got push=%h pend=%h want 00 00", n, push, pend);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0]  e_pend, e_push, e_drop;
      logic [63:0] e_grant;
      logic [23:0] e_gidx, gmask;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 8; i++) begin
            req_vld[i] = ($urandom_range(0, 2) == 0);
            req_addr[i*4 +: 4] = {($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7))};
            fifo_full[i] = ($urandom_range(0, 3) == 0);
         end
         cycle();
         e_pend = '0; e_push = '0; e_drop = '0; e_grant = '0; e_gidx = '0; gmask = '0;
         for (int i = 0; i < 8; i++) begin
            e_pend[i] = (m_pend[i] != 0);
            e_push[i] = (m_push[i] != 0);
            e_drop[i] = (m_drop[i] != 0);
            if (m_push[i] != 0) begin
               e_grant[i*8 + m_gidx[i]] = 1'b1;
               e_gidx[i*3 +: 3] = 3'(m_gidx[i]);
               gmask[i*3 +: 3] = 3'b111;
            end
         end
         total++; if (pend !== e_pend) begin bad++; $display("FAIL rnd_pend c%0d got=%h want=%h", n, pend, e_pend); end
         total++; if (push !== e_push) begin bad++; $display("FAIL rnd_push c%0d got=%h want=%h", n, push, e_push); end
         total++; if (drop !== e_drop) begin bad++; $display("FAIL rnd_drop c%0d got=%h want=%h", n, drop, e_drop); end
         total++; if (grant !== e_grant) begin bad++; $display("FAIL rnd_grant c%0d got=%h want=%h", n, grant, e_grant); end
         total++; if ((grant_idx & gmask) !== e_gidx) begin
            bad++; $display("FAIL rnd_gidx c%0d got=%h want=%h", n, grant_idx & gmask, e_gidx);
         end
         total++; if ((push & prev_full) !== 8'h00) begin
            bad++; $display("FAIL rnd_push_full c%0d got=%h want=00", n, push & prev_full);
         end
      end
      req_vld = '0; req_addr = '0; fifo_full = '0;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_drop();
      test_parallel();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
